// File: rtl/sum_accumulator_pkg.sv
// Shared types and constants for the sum accumulator block.
package sum_accumulator_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned CNT_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/sum_accumulator_if.sv
// Job/operand/result handshake bundle between a producer and the accumulator.
interface sum_accumulator_if
  import sum_accumulator_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) ();

  logic              start;
  logic [CNT_W-1:0]  count;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_sum;
  logic              out_ready;
  logic              busy;

  modport master (
    output start, count, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, busy
  );

  modport slave (
    input  start, count, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, busy
  );

endinterface

// File: rtl/full_adder.sv
// Ripple-carry adder; carry out of the top bit is discarded (modulo 2^Width).
module full_adder #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] in1_i,
  input  logic [Width-1:0] in2_i,
  output logic [Width-1:0] sum_o
);

  logic [Width-1:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < Width; i++) begin : g_bit
    assign sum_o[i] = in1_i[i] ^ in2_i[i] ^ carry[i];
    if (i < Width - 1) begin : g_carry
      assign carry[i+1] = (in1_i[i] & in2_i[i]) | (carry[i] & (in1_i[i] ^ in2_i[i]));
    end
  end

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates a counted job of 32-bit operands and hands the sum back once.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  sum_accumulator_if.slave  bus
);

  state_e            state_q;
  logic [DATA_W-1:0] acc_q;
  logic [CNT_W-1:0]  remaining_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;
  logic [DATA_W-1:0] acc_sum;

  full_adder #(
    .Width (DATA_W)
  ) u_adder (
    .in1_i (acc_q),
    .in2_i (bus.in_data),
    .sum_o (acc_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      remaining_q <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            acc_q       <= '0;
            remaining_q <= bus.count;
            busy_q      <= 1'b1;
            // An empty job skips straight to the result phase with a zero sum.
            if (bus.count != '0) begin
              state_q    <= StAccum;
              in_ready_q <= 1'b1;
            end else begin
              state_q     <= StDone;
              out_valid_q <= 1'b1;
            end
          end
        end
        StAccum: begin
          if (bus.in_valid && in_ready_q) begin
            acc_q       <= acc_sum;
            remaining_q <= remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
              state_q     <= StDone;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = acc_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter: CNT_W, 5, width of operand-count field; max operands per job is 2^CNT_W-1 = 31.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  job request, sampled only in IDLE.
REQ-005 Port: count  input  CNT_W  operands in job, sampled with start.
REQ-006 Port: in_valid  input  1  operand valid.
REQ-007 Port: in_data  input  32  operand.
REQ-008 Port: in_ready  output  1  operand accept; high only in ACCUM.
REQ-009 Port: out_valid  output  1  result valid; high only in DONE.
REQ-010 Port: out_sum  output  32  accumulated sum.
REQ-011 Port: out_ready  input  1  result consumer ready.
REQ-012 Port: busy  output  1  high whenever state != IDLE.

Function
REQ-013 FSM states: IDLE, ACCUM, DONE; encoded as 2-bit state register.
REQ-014 IDLE: start=1 and count!=0 -> ACCUM; acc<=0; remaining<=count.
REQ-015 IDLE: start=1 and count==0 -> DONE directly; acc<=0 (result 0, no operands consumed).
REQ-016 IDLE: start=0 -> stay; in_valid ignored (in_ready=0).
REQ-017 Beat accepted when in_valid & in_ready on a rising edge; only then acc<=acc+in_data and remaining<=remaining-1.
REQ-018 Addition modulo 2^32; carry out of bit 31 discarded; no overflow flag.
REQ-019 ACCUM: accepted beat with remaining==1 -> DONE on same edge; out_valid asserts the following cycle with final sum.
REQ-020 ACCUM with in_valid=0: hold acc, remaining, state indefinitely.
REQ-021 DONE: out_sum=acc stable, out_valid=1 until out_valid & out_ready; then -> IDLE.
REQ-022 start asserted in ACCUM or DONE ignored; not queued.
REQ-023 start in IDLE on same edge DONE->IDLE completes: not possible (one edge later); start is honoured only when state==IDLE at the edge.
REQ-024 out_sum reflects acc in all states (partial sum visible, valid only when out_valid=1).
REQ-025 Throughput: one operand per cycle in ACCUM; job of N operands occupies N+2 cycles minimum (start, N beats, handshake).

Reset
REQ-026 rst_n low asynchronously forces state=IDLE, acc=0, remaining=0.
REQ-027 Reset values: in_ready=0, out_valid=0, out_sum=0, busy=0.
REQ-028 Reset mid-job discards partial sum; no result emitted; next job requires new start.

Structure
REQ-029 Shared package holds state enum constants (IDLE=0, ACCUM=1, DONE=2) and DATA_W=32.
REQ-030 The addition is performed by one instance of the existing full_adder (32-bit ripple) with in1=acc, in2=in_data; no other adder is inferred.
REQ-031 Registers: state, acc[31:0], remaining[CNT_W-1:0]; all outputs derived from registers only (no input-to-output comb path except none).

Verification
REQ-032 start,count=3; operands 5,7,11 back-to-back; out_ready=1 -> out_valid one cycle after third beat, out_sum=23, then IDLE.
REQ-033 count=2; operands 0xFFFFFFFF, 0x00000002 -> out_sum=0x00000001 (wrap, carry dropped).
REQ-034 start,count=0 -> DONE next cycle, out_sum=0, no in_ready pulse; out_ready held low 5 cycles -> out_valid and out_sum stable throughout.
REQ-035 count=4; in_valid gaps between beats and start re-asserted mid-job -> start ignored, sum of 1,2,3,4 = 10.
REQ-036 count=3; rst_n pulled low after second beat -> outputs at reset values immediately; new job count=1, operand 9 -> out_sum=9.
